bsync_rx: RTL and testbench
===========================

Name: bsync_rx

Overview:
- Receive-side counterpart of the Bsync generator: samples an incoming BSYNC pulse train, measures the rising-edge-to-rising-edge period and classifies it against the two generator mode periods.
- Declares lock after a run of consistent periods and reports the detected mode on LED2.
- Flags loss of sync on period mismatch or when pulses stop.
- Sits on the board alongside the generator (loopback or second board) for link bring-up and LED status.

Parameters:
- SYNC_STAGES, 2: input synchronizer depth (minimum 2).
- CNT_W, 16: width of the period counter and period_out. Must hold TIMEOUT.
- PERIOD_A, 1000: nominal period in clocks for mode 0.
- PERIOD_B, 2000: nominal period in clocks for mode 1.
- TOL, 4: accepted deviation, ± clocks. Windows [P−TOL, P+TOL] must not overlap.
- LOCK_CNT, 3: consecutive matching periods required to lock.
- TIMEOUT, 4096: clocks without a rising edge before sync is declared lost. Must be > PERIOD_B+TOL.

Ports:
- IO_SYS_CLK  in  1  system clock.
- IO_RESET_KEY  in  1  asynchronous, active-high reset.
- IO_BSYNC_IN  in  1  asynchronous BSYNC pulse input.
- LED1  out  1  lock indicator.
- LED2  out  1  detected mode: 0=A, 1=B. Forced 0 while unlocked.
- period_out  out  CNT_W  last measured period in clocks.
- period_vld  out  1  one-cycle strobe when period_out updates.
- sync_err  out  1  one-cycle strobe on loss of lock.

Behaviour:
- **Reset.** Asynchronous, active-high. All synchronizer flops, the counter and all outputs go to 0; state goes to SEARCH. Release is sampled on the next IO_SYS_CLK edge.
- **Input path.**
  - SYNC_STAGES flops, then a previous-value flop.
  - edge = sync & ~prev.
  - A pin rising edge first sampled at clock edge k updates registered outputs at edge k+SYNC_STAGES+1 (k+3 by default).
- **Period counter.**
  - Held 0 in SEARCH.
  - On edge: loaded with 1. Otherwise increments by 1.
  - Measured period P = counter value at the edge cycle. Edges P clocks apart yield exactly P.
- **Classification.**
  - Class A if |P−PERIOD_A| ≤ TOL.
  - Class B if |P−PERIOD_B| ≤ TOL.
  - Otherwise NONE.
  - Unsigned compare, no wrap.
- **period_vld / period_out.** On every edge outside SEARCH: period_vld=1 for one cycle and period_out<=P. The first edge after SEARCH produces no strobe.
- **Timeout.** Counter == TIMEOUT and no edge in that cycle. An edge in the same cycle takes precedence.
- **States.**
  - SEARCH:
    - edge → ARMED.
  - ARMED:
    - edge with class c≠NONE → TRACK, cand=c, match=1.
    - edge with NONE → stay in ARMED.
    - timeout → SEARCH.
  - TRACK:
    - edge with class==cand → match+1; if match+1==LOCK_CNT → LOCKED, mode=cand.
    - edge with other non-NONE class → cand=new class, match=1.
    - edge with NONE → ARMED.
    - timeout → SEARCH.
  - LOCKED:
    - edge with class==mode → stay.
    - edge with other non-NONE class → TRACK, cand=new class, match=1, sync_err.
    - edge with NONE → ARMED, sync_err.
    - timeout → SEARCH, sync_err.
- **Outputs.**
  - LED1 = registered (state==LOCKED).
  - LED2 = registered mode while LOCKED, else 0.
  - sync_err is asserted in the same cycle LED1 falls.
- **Pulse width.** Ignored. Only rising edges matter. A high level held indefinitely produces a timeout.
- **Special case.** LOCK_CNT=1 locks on the first classified period.

Test Plan:
- **Reset.** Hold IO_RESET_KEY=1 with random IO_BSYNC_IN → LED1=0, LED2=0, period_vld=0, sync_err=0, period_out=0. Assert reset mid-LOCKED → outputs 0 immediately, without waiting for a clock edge.
- **Lock, mode A.** 4 pulses, period 1000, width 10 → period_vld on edges 2–4 with period_out=1000. LED1=1, LED2=0 three clocks after the 4th edge is sampled.
- **Mode switch.** While locked in A, send pulses at period 2000 → sync_err and LED1=0 at the first 2000 edge. LED1=1, LED2=1 at the third consecutive 2000 edge.
- **Tolerance.** Locked in A, periods 996 and 1004 → lock held, no sync_err. Period 995 → sync_err, state ARMED. Period 1005 from LOCKED → same result.
- **Loss.** Stop pulses while locked → LED1 falls with a sync_err strobe exactly 4096 clocks after the last edge's counter load. The next single edge produces no period_vld.
- **Edge vs timeout.** Edge arrives in the same cycle the counter reaches TIMEOUT → edge processed, no sync_err from timeout.

Source files
------------

// File: rtl/bsync_rx.sv
// BSYNC pulse-train receiver: measures the rising-edge period, classifies it against
// the two generator modes, and reports lock, detected mode and loss of sync.
module bsync_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PERIOD_A    = 1000,
  parameter int unsigned PERIOD_B    = 2000,
  parameter int unsigned TOL         = 4,
  parameter int unsigned LOCK_CNT    = 3,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic             IO_SYS_CLK,
  input  logic             IO_RESET_KEY,
  input  logic             IO_BSYNC_IN,
  output logic             LED1,
  output logic             LED2,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             sync_err
);

  // Room for LOCK_CNT+1 so a candidate count never wraps, even with LOCK_CNT=1.
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 2);

  localparam logic [CNT_W-1:0] A_LO   = CNT_W'((PERIOD_A > TOL) ? PERIOD_A - TOL : 0);
  localparam logic [CNT_W-1:0] A_HI   = CNT_W'(PERIOD_A + TOL);
  localparam logic [CNT_W-1:0] B_LO   = CNT_W'((PERIOD_B > TOL) ? PERIOD_B - TOL : 0);
  localparam logic [CNT_W-1:0] B_HI   = CNT_W'(PERIOD_B + TOL);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_VAL = MATCH_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    SEARCH,
    ARMED,
    TRACK,
    LOCKED
  } state_t;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;

  state_t               state;
  state_t               state_n;
  logic                 cand;
  logic                 cand_n;
  logic                 mode;
  logic                 mode_n;
  logic [MATCH_W-1:0]   match;
  logic [MATCH_W-1:0]   match_n;

  logic                 is_a;
  logic                 is_b;
  logic                 cls_ok;
  logic                 timeout;

  logic                 led1_n;
  logic                 led2_n;
  logic                 vld_n;
  logic                 err_n;
  logic [CNT_W-1:0]     pout_n;

  // Rise detect is registered so the FSM sees it SYNC_STAGES+1 clocks after the pin.
  always_ff @(posedge IO_SYS_CLK or posedge IO_RESET_KEY) begin
    if (IO_RESET_KEY) begin
      sync_ff <= '0;
      prev    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], IO_BSYNC_IN};
      prev    <= sync_ff[SYNC_STAGES-1];
      rise    <= sync_ff[SYNC_STAGES-1] & ~prev;
    end
  end

  always_comb begin
    is_a    = (cnt >= A_LO) && (cnt <= A_HI);
    is_b    = (cnt >= B_LO) && (cnt <= B_HI);
    cls_ok  = is_a | is_b;
    timeout = (cnt == TO_VAL) && !rise;
  end

  // State register, tracking data and registered outputs.
  always_ff @(posedge IO_SYS_CLK or posedge IO_RESET_KEY) begin
    if (IO_RESET_KEY) begin
      state      <= SEARCH;
      cand       <= 1'b0;
      mode       <= 1'b0;
      match      <= '0;
      cnt        <= '0;
      LED1       <= 1'b0;
      LED2       <= 1'b0;
      period_out <= '0;
      period_vld <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      mode       <= mode_n;
      match      <= match_n;
      cnt        <= cnt_n;
      LED1       <= led1_n;
      LED2       <= led2_n;
      period_out <= pout_n;
      period_vld <= vld_n;
      sync_err   <= err_n;
    end
  end

  // Next-state logic; is_b doubles as the class bit (0=A, 1=B) when cls_ok.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    mode_n  = mode;
    match_n = match;
    unique case (state)
      SEARCH: begin
        if (rise) state_n = ARMED;
      end
      ARMED: begin
        if (rise) begin
          if (cls_ok) begin
            state_n = TRACK;
            cand_n  = is_b;
            match_n = MATCH_W'(1);
          end
        end else if (timeout) begin
          state_n = SEARCH;
        end
      end
      TRACK: begin
        if (rise) begin
          if (!cls_ok) begin
            state_n = ARMED;
          end else if (is_b == cand) begin
            match_n = match + 1'b1;
          end else begin
            cand_n  = is_b;
            match_n = MATCH_W'(1);
          end
        end else if (timeout) begin
          state_n = SEARCH;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!cls_ok) begin
            state_n = ARMED;
          end else if (is_b != mode) begin
            state_n = TRACK;
            cand_n  = is_b;
            match_n = MATCH_W'(1);
          end
        end else if (timeout) begin
          state_n = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
    // A candidate run reaching LOCK_CNT locks at once; covers LOCK_CNT=1 from ARMED.
    if (state != LOCKED && state_n == TRACK && match_n >= LOCK_VAL) begin
      state_n = LOCKED;
      mode_n  = cand_n;
    end
  end

  // Output and counter next values.
  always_comb begin
    led1_n = (state_n == LOCKED);
    led2_n = (state_n == LOCKED) && mode_n;
    vld_n  = rise && (state != SEARCH);
    pout_n = vld_n ? cnt : period_out;
    err_n  = (state == LOCKED) && (state_n != LOCKED);
    if (rise) begin
      cnt_n = CNT_W'(1);
    end else if (state == SEARCH || timeout) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bsync_rx.sv
// Bench for bsync_rx: directed lock/tolerance/loss scenarios plus random pulse trains,
// checked every cycle against a period/event model built from pin rise times.
module tb_bsync_rx;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;
  localparam int PA          = 1000;
  localparam int PB          = 2000;
  localparam int TOL         = 4;
  localparam int LOCK_CNT    = 3;
  localparam int TIMEOUT     = 4096;
  localparam int HIST_N      = 131072;
  localparam int NEVER       = 1 << 30;
  localparam int LAT         = SYNC_STAGES + 2;  // pin set at negedge t shows at negedge t+LAT

  localparam int S_SEARCH = 0;
  localparam int S_ARMED  = 1;
  localparam int S_TRACK  = 2;
  localparam int S_LOCKED = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             pin;
  logic             led1;
  logic             led2;
  logic             vld;
  logic             err;
  logic [CNT_W-1:0] pout;

  bsync_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .PERIOD_A   (PA),
    .PERIOD_B   (PB),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .IO_SYS_CLK  (clk),
    .IO_RESET_KEY(rst),
    .IO_BSYNC_IN (pin),
    .LED1        (led1),
    .LED2        (led2),
    .period_out  (pout),
    .period_vld  (vld),
    .sync_err    (err)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int t         = 0;
  int rel       = NEVER;
  int fall_t    = -1;
  int last_rise = 0;
  bit hist [HIST_N];

  int m_st    = S_SEARCH;
  int m_cand  = 0;
  int m_match = 0;
  int m_mode  = 0;
  int m_last  = 0;
  bit e_led1  = 1'b0;
  bit e_led2  = 1'b0;
  bit e_vld   = 1'b0;
  bit e_err   = 1'b0;
  int e_pout  = 0;

  function automatic bit h(int x);
    if (x < rel || x < 0 || x >= HIST_N) return 1'b0;
    return hist[x];
  endfunction

  function automatic int classify(int p);
    if (p - PA <= TOL && PA - p <= TOL) return 1;
    if (p - PB <= TOL && PB - p <= TOL) return 2;
    return 0;
  endfunction

  // Applies the receiver rules to the pin sample taken at clock s.
  task automatic model(int s);
    int p;
    int c;
    bit was_locked;
    e_vld = 1'b0;
    e_err = 1'b0;
    if (rst || s < rel) return;
    if (m_st == S_SEARCH) begin
      if (h(s) && !h(s - 1)) begin
        m_st   = S_ARMED;
        m_last = s;
      end
    end else begin
      p = s - m_last;
      was_locked = (m_st == S_LOCKED);
      if (h(s) && !h(s - 1)) begin
        e_vld  = 1'b1;
        e_pout = p;
        m_last = s;
        c = classify(p);
        if (c == 0) begin
          if (was_locked) e_err = 1'b1;
          m_st = S_ARMED;
        end else if (was_locked) begin
          if (c - 1 != m_mode) begin
            e_err   = 1'b1;
            m_st    = S_TRACK;
            m_cand  = c - 1;
            m_match = 1;
          end
        end else if (m_st == S_TRACK && c - 1 == m_cand) begin
          m_match++;
        end else begin
          m_st    = S_TRACK;
          m_cand  = c - 1;
          m_match = 1;
        end
        if (!was_locked && m_st == S_TRACK && m_match >= LOCK_CNT) begin
          m_st   = S_LOCKED;
          m_mode = m_cand;
        end
      end else if (p == TIMEOUT) begin
        if (was_locked) e_err = 1'b1;
        m_st = S_SEARCH;
      end
    end
    e_led1 = (m_st == S_LOCKED);
    e_led2 = (m_st == S_LOCKED) && (m_mode == 1);
  endtask

  task automatic set_reset(bit v);
    rst = v;
    if (v) begin
      rel     = NEVER;
      m_st    = S_SEARCH;
      m_cand  = 0;
      m_match = 0;
      m_mode  = 0;
      e_led1  = 1'b0;
      e_led2  = 1'b0;
      e_vld   = 1'b0;
      e_err   = 1'b0;
      e_pout  = 0;
    end else begin
      rel = t;
    end
  endtask

  task automatic step();
    if (t >= HIST_N - 1) begin
      failures++;
      $display("FAIL step_budget t=%0d limit=%0d", t, HIST_N - 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "cycle budget exhausted");
    end
    hist[t] = pin;
    @(negedge clk);
    t++;
    if (t == fall_t) pin = 1'b0;
    model(t - LAT);
    checks++;
    assert ({led1, led2, vld, err, pout} === {e_led1, e_led2, e_vld, e_err, CNT_W'(e_pout)})
    else begin
      failures++;
      $error("FAIL cycle t=%0d observed led1=%b led2=%b vld=%b err=%b pout=%0d expected led1=%b led2=%b vld=%b err=%b pout=%0d",
             t, led1, led2, vld, err, pout, e_led1, e_led2, e_vld, e_err, e_pout);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed output check; pexp < 0 skips period_out.
  task automatic expect_out(string tag, bit v, int pexp, bit l1, bit l2, bit e);
    chk({tag, "_vld"}, int'(vld), int'(v));
    if (pexp >= 0) chk({tag, "_pout"}, int'(pout), pexp);
    chk({tag, "_led1"}, int'(led1), int'(l1));
    chk({tag, "_led2"}, int'(led2), int'(l2));
    chk({tag, "_err"}, int'(err), int'(e));
  endtask

  task automatic start_train();
    last_rise = t;
  endtask

  // Raise the pin so its rise is sampled gap clocks after the previous one, then
  // advance to the cycle where that edge shows on the outputs. width=0 holds high.
  task automatic pulse(int gap, int width);
    while (t < last_rise + gap) step();
    pin       = 1'b1;
    last_rise = t;
    fall_t    = (width > 0) ? t + width : -1;
    repeat (LAT) step();
  endtask

  initial begin
    int tr;
    int r;
    int gap;
    pin = 1'b0;
    set_reset(1'b1);
    repeat (20) begin
      pin = 1'($urandom_range(0, 1));
      step();
    end
    expect_out("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    pin = 1'b0;
    step();
    set_reset(1'b0);
    repeat (10) step();

    start_train();
    pulse(5, 10);
    expect_out("a_e1", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    pulse(PA, 10);
    expect_out("a_e2", 1'b1, PA, 1'b0, 1'b0, 1'b0);
    pulse(PA, 10);
    expect_out("a_e3", 1'b1, PA, 1'b0, 1'b0, 1'b0);
    pulse(PA, 10);
    expect_out("a_e4", 1'b1, PA, 1'b1, 1'b0, 1'b0);

    pulse(PA - TOL, 10);
    expect_out("tol_lo", 1'b1, PA - TOL, 1'b1, 1'b0, 1'b0);
    pulse(PA + TOL, 10);
    expect_out("tol_hi", 1'b1, PA + TOL, 1'b1, 1'b0, 1'b0);
    pulse(PA - TOL - 1, 10);
    expect_out("tol_under", 1'b1, PA - TOL - 1, 1'b0, 1'b0, 1'b1);
    pulse(PA, 10);
    pulse(PA, 10);
    expect_out("armed_m2", 1'b1, PA, 1'b0, 1'b0, 1'b0);
    pulse(PA, 10);
    expect_out("relock1", 1'b1, PA, 1'b1, 1'b0, 1'b0);
    pulse(PA + TOL + 1, 10);
    expect_out("tol_over", 1'b1, PA + TOL + 1, 1'b0, 1'b0, 1'b1);
    repeat (3) pulse(PA, 10);
    expect_out("relock2", 1'b1, PA, 1'b1, 1'b0, 1'b0);

    pulse(PB, 10);
    expect_out("sw_b1", 1'b1, PB, 1'b0, 1'b0, 1'b1);
    pulse(PB, 10);
    expect_out("sw_b2", 1'b1, PB, 1'b0, 1'b0, 1'b0);
    pulse(PB, 10);
    expect_out("sw_b3", 1'b1, PB, 1'b1, 1'b1, 1'b0);

    repeat (20) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      gap = PA + int'($urandom_range(0, 2 * TOL)) - TOL;
      else if (r <= 6) gap = PB + int'($urandom_range(0, 2 * TOL)) - TOL;
      else if (r == 7) gap = PA + TOL + 1 + int'($urandom_range(0, 3));
      else if (r == 8) gap = PB - TOL - 1 - int'($urandom_range(0, 3));
      else             gap = int'($urandom_range(20, 600));
      pulse(gap, int'($urandom_range(1, 15)));
    end

    repeat (TIMEOUT + 200) step();
    chk("idle_led1", int'(led1), 0);

    start_train();
    pulse(5, 10);
    repeat (3) pulse(PA, 10);
    expect_out("loss_lock", 1'b1, PA, 1'b1, 1'b0, 1'b0);
    tr = last_rise;
    while (t < tr + LAT + TIMEOUT - 1) step();
    expect_out("loss_before", 1'b0, PA, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("loss_at", 1'b0, PA, 1'b0, 1'b0, 1'b1);
    step();
    chk("loss_after_err", int'(err), 0);
    pulse(TIMEOUT + 200, 10);
    expect_out("search_edge", 1'b0, PA, 1'b0, 1'b0, 1'b0);

    pulse(TIMEOUT, 10);
    expect_out("edge_vs_to", 1'b1, TIMEOUT, 1'b0, 1'b0, 1'b0);
    pulse(PA, 10);
    expect_out("after_evt", 1'b1, PA, 1'b0, 1'b0, 1'b0);

    pulse(PA, 0);
    repeat (TIMEOUT + 100) step();
    chk("held_high_led1", int'(led1), 0);
    pin = 1'b0;
    repeat (5) step();

    start_train();
    pulse(5, 10);
    repeat (3) pulse(PA, 10);
    repeat (50) step();
    chk("pre_rst_led1", int'(led1), 1);
    set_reset(1'b1);
    #1;
    expect_out("async_rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    set_reset(1'b0);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
